// File: rtl/jt1943_objdma_pkg.sv
// Shared definitions for the 1943 object DMA: FSM encoding, source-address
// layout and object geometry.
package jt1943_objdma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_ADDR = 3'd2,
    ST_COPY = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [12:0] OBJ_BASE      = 13'h1000;
  localparam int          BYTES_PER_OBJ = 4;

  // idx = {obj, byte}; objects sit 2**stride_log2 bytes apart above OBJ_BASE
  function automatic logic [12:0] src_addr(input logic [8:0] idx, input int stride_log2);
    logic [12:0] obj_off;
    obj_off = 13'(idx[8:2]) << stride_log2;
    return OBJ_BASE + obj_off + 13'(idx[1:0]);
  endfunction

endpackage

// File: rtl/jt1943_objdma_buf.sv
// Double-buffered object line buffer: 1024x8 simple dual-port RAM with a
// DMA write port and a registered renderer read port.
module jt1943_objdma_buf (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [9:0] waddr,
  input  logic [7:0] wdata,
  input  logic [9:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [1024];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register reset only clears the data latch, never the array
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= 8'h00;
    else     rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/jt1943_objdma.sv
// Object DMA engine: on each vertical blank, borrows the main CPU bus and
// copies the object table into the back bank, swapping banks on completion.
module jt1943_objdma
  import jt1943_objdma_pkg::*;
#(
  parameter int OBJCNT      = 128,
  parameter int STRIDE_LOG2 = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen6,
  input  logic        LVBL,
  input  logic        bus_ack,
  input  logic [7:0]  ram_dout,
  output logic        bus_req,
  output logic        blcnten,
  output logic [12:0] obj_AB,
  input  logic [8:0]  buf_addr,
  output logic [7:0]  buf_dout,
  output logic        dma_busy,
  output logic        bank
);

  localparam logic [8:0] LAST_IDX = 9'(BYTES_PER_OBJ * OBJCNT - 1);

  state_t      state_q, state_d;
  logic [8:0]  idx_q, idx_d;
  logic        lvbl_q;
  logic        bus_req_q, bus_req_d;
  logic        blcnten_q, blcnten_d;
  logic [12:0] obj_ab_q, obj_ab_d;
  logic        bank_q, bank_d;
  logic        wr_en;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bus_req_d = bus_req_q;
    blcnten_d = blcnten_q;
    obj_ab_d  = obj_ab_q;
    bank_d    = bank_q;
    wr_en     = 1'b0;
    if (cen6) begin
      if (state_q != ST_IDLE && LVBL) begin
        // Blank ended early: release the bus, keep the front bank as is
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
        blcnten_d = 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (lvbl_q && !LVBL) begin
              state_d   = ST_REQ;
              idx_d     = 9'd0;
              bus_req_d = 1'b1;
            end
          end
          ST_REQ: begin
            if (bus_ack) begin
              state_d   = ST_ADDR;
              blcnten_d = 1'b1;
              obj_ab_d  = src_addr(idx_q, STRIDE_LOG2);
            end
          end
          ST_ADDR: begin
            if (!bus_ack) begin
              state_d   = ST_REQ;
              blcnten_d = 1'b0;
            end else begin
              state_d = ST_COPY;
            end
          end
          ST_COPY: begin
            // A lost bus leaves idx pointing at the byte still to be written
            if (!bus_ack) begin
              state_d   = ST_REQ;
              blcnten_d = 1'b0;
            end else begin
              wr_en = 1'b1;
              if (idx_q == LAST_IDX) begin
                state_d   = ST_DONE;
                blcnten_d = 1'b0;
              end else begin
                idx_d    = idx_q + 9'd1;
                obj_ab_d = src_addr(idx_q + 9'd1, STRIDE_LOG2);
              end
            end
          end
          ST_DONE: begin
            state_d   = ST_IDLE;
            bus_req_d = 1'b0;
            bank_d    = ~bank_q;
          end
          default: begin
            state_d   = ST_IDLE;
            bus_req_d = 1'b0;
            blcnten_d = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= 9'd0;
      lvbl_q    <= 1'b0;
      bus_req_q <= 1'b0;
      blcnten_q <= 1'b0;
      obj_ab_q  <= 13'd0;
      bank_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      bus_req_q <= bus_req_d;
      blcnten_q <= blcnten_d;
      obj_ab_q  <= obj_ab_d;
      bank_q    <= bank_d;
      if (cen6) lvbl_q <= LVBL;
    end
  end

  jt1943_objdma_buf u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr ({~bank_q, idx_q}),
    .wdata (ram_dout),
    .raddr ({bank_q, buf_addr}),
    .rdata (buf_dout)
  );

  // Gating with bus_ack drops the RAM takeover the moment the CPU reclaims the bus
  assign blcnten  = blcnten_q & bus_ack;
  assign bus_req  = bus_req_q;
  assign obj_AB   = obj_ab_q;
  assign bank     = bank_q;
  assign dma_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_jt1943_objdma.sv
// Scoreboard bench for jt1943_objdma: stimulus queues expectations, monitors
// compare them against buffer reads, status samples and the address stream.
module tb_jt1943_objdma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen6;
  logic        LVBL = 1'b1;
  logic        bus_ack = 1'b0;
  logic [7:0]  ram_dout = 8'h00;
  logic        bus_req;
  logic        blcnten;
  logic [12:0] obj_AB;
  logic [8:0]  buf_addr = 9'd0;
  logic [7:0]  buf_dout;
  logic        dma_busy;
  logic        bank;

  jt1943_objdma dut (
    .clk      (clk),
    .rst      (rst),
    .cen6     (cen6),
    .LVBL     (LVBL),
    .bus_ack  (bus_ack),
    .ram_dout (ram_dout),
    .bus_req  (bus_req),
    .blcnten  (blcnten),
    .obj_AB   (obj_AB),
    .buf_addr (buf_addr),
    .buf_dout (buf_dout),
    .dma_busy (dma_busy),
    .bank     (bank)
  );

  always #5 clk = ~clk;

  logic [1:0] cdiv = 2'd0;
  always @(negedge clk) cdiv <= cdiv + 2'd1;
  assign cen6 = (cdiv == 2'd0);

  // Main RAM model: byte = obj ^ byte*0x40, xored with a per-frame salt
  logic [7:0] salt = 8'h00;
  function automatic logic [7:0] model(input logic [8:0] idx, input logic [7:0] s);
    return {1'b0, idx[8:2]} ^ {idx[1:0], 6'b000000} ^ s;
  endfunction
  function automatic logic [12:0] src(input int i);
    return 13'h1000 + 13'(i / 4) * 13'd32 + 13'(i % 4);
  endfunction
  always @(posedge clk) ram_dout <= obj_AB[12] ? model({obj_AB[11:5], obj_AB[1:0]}, salt) : 8'h00;

  int checks = 0;
  int errors = 0;

  typedef struct { string name; logic [31:0] exp; int sel; } stat_t;
  typedef struct { logic [8:0] addr; logic [7:0] exp; } rd_t;
  stat_t       stat_q[$];
  rd_t         rd_q[$];
  logic [12:0] ab_q[$];
  int          len_q[$];
  logic        rd_req = 1'b0;
  logic        rd_seen = 1'b0;
  bit          ab_en = 1'b0;
  int          last_ab = -1;

  localparam int S_REQ = 0, S_BLC = 1, S_BANK = 2, S_BUSY = 3, S_AB = 4, S_DOUT = 5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string what);
    checks++;
    errors++;
    $display("FAIL timeout_%s: condition never reached within bound", what);
  endtask

  // ---------------- monitors ----------------
  always @(posedge clk) rd_seen <= rd_req;

  initial begin
    stat_t       s;
    rd_t         r;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      if (rd_seen) begin
        if (rd_q.size() == 0) timeout_fail("rd_queue_empty");
        else begin
          r = rd_q.pop_front();
          check($sformatf("rd_%03h", r.addr), 32'(buf_dout), 32'(r.exp));
        end
      end
      while (stat_q.size() > 0) begin
        s = stat_q.pop_front();
        case (s.sel)
          S_REQ:   act = 32'(bus_req);
          S_BLC:   act = 32'(blcnten);
          S_BANK:  act = 32'(bank);
          S_BUSY:  act = 32'(dma_busy);
          S_AB:    act = 32'(obj_AB);
          default: act = 32'(buf_dout);
        endcase
        check(s.name, act, s.exp);
      end
    end
  end

  initial begin
    int run;
    run = 0;
    forever begin
      @(posedge clk);
      if (cen6) begin
        #2;
        if (blcnten) check("blcnten_needs_ack", 32'(bus_ack), 32'd1);
        if (ab_en && blcnten && int'(obj_AB) != last_ab) begin
          last_ab = int'(obj_AB);
          if (ab_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL obj_AB_extra: got %0h, expected no further address", obj_AB);
          end else check("obj_AB_seq", 32'(obj_AB), 32'(ab_q.pop_front()));
        end
        if (bus_req) run++;
        else if (run > 0) begin
          if (len_q.size() > 0) check("bus_req_len", 32'(run), 32'(len_q.pop_front()));
          run = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    do @(posedge clk); while (!cen6);
    #1;
  endtask

  task automatic expect_stat(input string n, input int sel, input logic [31:0] e);
    stat_q.push_back('{name: n, exp: e, sel: sel});
  endtask

  task automatic rd(input logic [8:0] a, input logic [7:0] e);
    buf_addr = a;
    rd_q.push_back('{addr: a, exp: e});
    rd_req = 1'b1;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic wait_req();
    for (int n = 0; n < 20; n++) begin
      if (bus_req) return;
      tick();
    end
    timeout_fail("bus_req");
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 3000; n++) begin
      if (!dma_busy) return;
      tick();
    end
    timeout_fail("idle");
  endtask

  task automatic wait_ab(input int i);
    for (int n = 0; n < 3000; n++) begin
      if (blcnten && obj_AB == src(i)) return;
      tick();
    end
    timeout_fail($sformatf("idx_%0d", i));
  endtask

  task automatic load_ab();
    ab_q.delete();
    for (int i = 0; i < 512; i++) ab_q.push_back(src(i));
    last_ab = -1;
    ab_en   = 1'b1;
  endtask

  task automatic expect_reset_values(input string tag);
    expect_stat({tag, "_bus_req"}, S_REQ, 32'd0);
    expect_stat({tag, "_blcnten"}, S_BLC, 32'd0);
    expect_stat({tag, "_obj_AB"}, S_AB, 32'd0);
    expect_stat({tag, "_bank"}, S_BANK, 32'd0);
    expect_stat({tag, "_busy"}, S_BUSY, 32'd0);
    expect_stat({tag, "_buf_dout"}, S_DOUT, 32'd0);
  endtask

  task automatic end_frame(input logic [31:0] exp_bank, input string tag);
    bus_ack = 1'b0;
    LVBL    = 1'b1;
    ab_en   = 1'b0;
    expect_stat({tag, "_bank"}, S_BANK, exp_bank);
    check({tag, "_addr_missing"}, 32'(ab_q.size()), 32'd0);
    repeat (3) tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    expect_reset_values("reset");
    rst = 1'b0;
    repeat (3) tick();

    // Frame A: nominal copy, bus_ack seen two ticks after bus_req rises
    salt = 8'h00;
    load_ab();
    len_q.push_back(2 + 515 - 1);
    LVBL = 1'b0;
    tick();
    expect_stat("req_delay", S_REQ, 32'd1);
    tick();
    bus_ack = 1'b1;
    wait_idle();
    end_frame(32'd1, "frameA");
    rd(9'h1FD, 8'h3F);  // obj 127, byte 1
    rd(9'h000, 8'h00);
    rd(9'h006, 8'h81);  // obj 1, byte 2
    rd(9'h0AB, 8'hEA);  // obj 42, byte 3

    // Frame B: bus lost at idx 200 for 10 ticks, renderer sweeping meanwhile
    salt = 8'h5A;
    load_ab();
    LVBL = 1'b0;
    fork
      begin
        wait_req();
        bus_ack = 1'b1;
        wait_ab(200);
        bus_ack = 1'b0;
        #1;
        expect_stat("loss_blcnten", S_BLC, 32'd0);
        expect_stat("loss_bus_req", S_REQ, 32'd1);
        repeat (10) tick();
        expect_stat("loss_hold_req", S_REQ, 32'd1);
        expect_stat("loss_hold_blc", S_BLC, 32'd0);
        bus_ack = 1'b1;
        wait_idle();
      end
      begin
        int  a;
        bit  seen;
        int  after;
        a = 0;
        seen = 1'b0;
        after = 0;
        for (int n = 0; n < 8000 && after < 8; n++) begin
          if (dma_busy) seen = 1'b1;
          if (seen && !dma_busy) begin
            after++;
            rd(9'(a), model(9'(a), 8'h5A));
          end else begin
            rd(9'(a), model(9'(a), 8'h00));
          end
          a = (a + 7) % 512;
        end
        if (after < 8) timeout_fail("sweep_swap");
      end
    join
    end_frame(32'd0, "frameB");
    for (int i = 0; i < 512; i++) rd(9'(i), model(9'(i), 8'h5A));

    // Frame C: blank ends at idx 100
    salt = 8'hC3;
    LVBL = 1'b0;
    wait_req();
    bus_ack = 1'b1;
    wait_ab(100);
    expect_stat("pre_abort_req", S_REQ, 32'd1);
    expect_stat("pre_abort_blc", S_BLC, 32'd1);
    LVBL = 1'b1;
    tick();
    expect_stat("abort_bus_req", S_REQ, 32'd0);
    expect_stat("abort_blcnten", S_BLC, 32'd0);
    expect_stat("abort_busy", S_BUSY, 32'd0);
    expect_stat("abort_bank", S_BANK, 32'd0);
    bus_ack = 1'b0;
    rd(9'd0, model(9'd0, 8'h5A));
    rd(9'd99, model(9'd99, 8'h5A));
    rd(9'd100, model(9'd100, 8'h5A));
    rd(9'd511, model(9'd511, 8'h5A));
    repeat (3) tick();

    // Frame D: bus already granted, moves the front bank to 1
    salt = 8'h11;
    load_ab();
    len_q.push_back(515);
    bus_ack = 1'b1;
    LVBL = 1'b0;
    wait_req();
    wait_idle();
    end_frame(32'd1, "frameD");
    rd(9'd3, model(9'd3, 8'h11));
    rd(9'd508, model(9'd508, 8'h11));

    // Frame E: reset at idx 300
    salt = 8'h22;
    LVBL = 1'b0;
    wait_req();
    bus_ack = 1'b1;
    wait_ab(300);
    rst = 1'b1;
    @(posedge clk);
    #1;
    expect_reset_values("midrst");
    rst = 1'b0;
    bus_ack = 1'b0;
    repeat (3) tick();
    expect_stat("no_retrigger_busy", S_BUSY, 32'd0);
    LVBL = 1'b1;
    repeat (3) tick();

    // Frame F: full copy from idx 0 after reset
    salt = 8'h33;
    load_ab();
    len_q.push_back(515);
    bus_ack = 1'b1;
    LVBL = 1'b0;
    wait_req();
    wait_idle();
    end_frame(32'd1, "frameF");
    for (int i = 0; i < 512; i++) rd(9'(i), model(9'(i), 8'h33));

    repeat (4) @(posedge clk);
    check("len_left", 32'(len_q.size()), 32'd0);
    check("rd_left", 32'(rd_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion before time limit");
    $fatal(1, "watchdog");
  end

endmodule
